mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

- Shares the single Avalon-MM master port between instruction fetch and the data-memory stage.
- Arbitrates the two requesters and sequences each bus transaction through `waitrequest`.
- Generates word-aligned address and byteenable from the MIPS load/store opcode, and returns the raw read word plus byteenable for the writeback-stage load filter.
- Drives per-requester stall signals back to the pipeline.

## Interface
- `DATA_PRIORITY`, default 1: 1 = data wins simultaneous requests, 0 = fetch wins.
- `TIMEOUT_CYCLES`, default 255: `waitrequest` cycles tolerated before abort (used only with `MEM_ARB_TIMEOUT_EN`).
- `clk`  in  1  clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_req`  in  1  fetch request; held until `instr_valid`.
- `instr_address`  in  32  fetch byte address.
- `instr_rdata`  out  32  fetched word.
- `instr_valid`  out  1  one-cycle completion pulse.
- `instr_stall`  out  1  `instr_req & ~instr_valid`.
- `data_read` / `data_write`  in  1  data request; held until `data_valid`.
- `data_op`  in  6  opcode (LB 100000, LH 100001, LWL 100010, LW 100011, LBU 100100, LHU 100101, LWR 100110, SB 101000, SH 101001, SW 101011).
- `data_address`  in  32  byte address.
- `data_wdata`  in  32  store data, already lane-shifted by the datapath.
- `data_rdata`  out  32  raw read word, unfiltered.
- `data_byteenable`  out  4  lanes used, forwarded to the load filter.
- `data_valid`  out  1  one-cycle completion pulse.
- `data_error`  out  1  qualifies `data_valid`: misaligned access or timeout.
- `data_stall`  out  1  `(data_read|data_write) & ~data_valid`.
- `avm_address`  out  32  word address, bits [1:0] = 0.
- `avm_read` / `avm_write`  out  1  bus strobes.
- `avm_writedata`  out  32  store data.
- `avm_byteenable`  out  4  bus lanes.
- `avm_readdata`  in  32  valid in the cycle `waitrequest` is low.
- `avm_waitrequest`  in  1  slave stall.

## Operation
**States:** IDLE, BUS.
- **IDLE:**
  - Samples requests. If both are active, grant per `DATA_PRIORITY`. If `data_read` and `data_write` are both high, treat as a write.
  - On grant, latch address, byteenable, wdata and requester ID; go to BUS.
- **BUS:**
  - Holds `avm_read` or `avm_write` and all bus outputs stable.
  - On an edge where `avm_waitrequest`=0: capture `avm_readdata`, pulse the granted requester's valid, return to IDLE.
- **Byteenable, a = address[1:0]:**
  - LB/LBU/SB: 0001<<a.
  - LH/LHU/SH: a[1] ? 1100 : 0011.
  - LW/SW: 1111.
  - LWL: a=0→0001, 1→0011, 2→0111, 3→1111.
  - LWR: a=0→1111, 1→1110, 2→1100, 3→1000.
  - Fetch: 1111.
- **Misaligned access** (LH/LHU/SH with a[0]=1, or LW/SW with a≠0):
  - No bus cycle is issued.
  - Next cycle: `data_valid`=1, `data_error`=1, `data_rdata`=0.
  - FSM stays in IDLE.
- **Unknown `data_op`:** treated as LW/SW.
- **Reset values:** every output is 0, FSM is IDLE, no grant latched.
- **Reset asserted in BUS:** the transaction is abandoned, strobes are 0 after that edge, and no valid pulse is issued.

## Timing
- Request seen high at edge N in IDLE → bus strobe asserted from cycle N+1.
- `waitrequest` low at edge N+1+k → valid pulse and `rdata` during cycle N+2+k.
  - FSM is in IDLE during that cycle and may accept a new request at the same edge it accepts.
  - Zero-wait throughput: one transaction per 2 cycles.
- `rdata` holds its value until the next completion for that requester.
- Requester inputs are not re-sampled during BUS. Changing them mid-transaction has no effect.
- The losing requester's stall stays high. It is granted at the first IDLE edge where it is the only request, or where priority favours it.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:**
  - An 8+ bit counter increments each BUS cycle with `waitrequest`=1.
  - When the count reaches `TIMEOUT_CYCLES`: drop strobes, pulse the requester's valid, assert `data_error` (data requests only), return to IDLE.
  - The counter clears on every grant.
- **Not defined:** no counter, BUS waits indefinitely, and `data_error` reflects misalignment only.

## Test plan
- LW addr 0x100, waitrequest=0, readdata 0xDEADBEEF → `avm_address`=0x100, byteenable 1111, `data_valid` in 2nd cycle, `data_rdata`=0xDEADBEEF.
- LB addr 0x203 with waitrequest high 3 cycles → byteenable 1000, strobe held 4 cycles, single valid pulse, `data_byteenable`=1000.
- Simultaneous fetch 0xBFC00000 and SW 0x40, `DATA_PRIORITY`=1 → write first with byteenable 1111; fetch granted at the next IDLE; `instr_stall` high throughout until its valid.
- LH addr 0x11 → no `avm_read`, `data_valid`=1 and `data_error`=1 the next cycle.
- LWL addr 0x22 → byteenable 0111; LWR addr 0x21 → byteenable 1110.
- Reset pulsed while waitrequest=1 in BUS → all outputs 0 next cycle, no valid; with `MEM_ARB_TIMEOUT_EN`, waitrequest stuck high → abort after 255 cycles with `data_error`=1.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Avalon-MM master bus bundle shared by instruction fetch and data memory.
interface mem_bus_arbiter_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-MM master port between instruction fetch and the data-memory stage.
// Optional define MEM_ARB_TIMEOUT_EN aborts transactions stalled too long by waitrequest.
module mem_bus_arbiter #(
    parameter int unsigned DATA_PRIORITY  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_req,
    input  logic [31:0]       instr_address,
    output logic [31:0]       instr_rdata,
    output logic              instr_valid,
    output logic              instr_stall,
    input  logic              data_read,
    input  logic              data_write,
    input  logic [5:0]        data_op,
    input  logic [31:0]       data_address,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic [3:0]        data_byteenable,
    output logic              data_valid,
    output logic              data_error,
    output logic              data_stall,
    mem_bus_arbiter_if.master bus
);
    typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    state_t      state_q, state_d;
    logic        is_data_q, rd_q, wr_q;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [1:0]  byte_off;
    logic [3:0]  be_c;
    logic        misalign_c;
    logic        instr_req_c, data_req_c, grant_data_c, grant_instr_c;
    logic        start_c, fault_c, done_c, timeout_c;
    logic        unused_bits;

    assign byte_off    = data_address[1:0];
    assign unused_bits = ^instr_address[1:0];

    // Lane selection and alignment check from the load/store opcode
    always_comb begin
        be_c       = 4'b1111;
        misalign_c = 1'b0;
        case (data_op)
            OP_LB, OP_LBU, OP_SB: be_c = 4'b0001 << byte_off;
            OP_LH, OP_LHU, OP_SH: begin
                be_c       = byte_off[1] ? 4'b1100 : 4'b0011;
                misalign_c = byte_off[0];
            end
            OP_LWL: begin
                case (byte_off)
                    2'd0: be_c = 4'b0001;
                    2'd1: be_c = 4'b0011;
                    2'd2: be_c = 4'b0111;
                    2'd3: be_c = 4'b1111;
                endcase
            end
            OP_LWR: begin
                case (byte_off)
                    2'd0: be_c = 4'b1111;
                    2'd1: be_c = 4'b1110;
                    2'd2: be_c = 4'b1100;
                    2'd3: be_c = 4'b1000;
                endcase
            end
            default: misalign_c = (byte_off != 2'b00);
        endcase
    end

    // A requester whose valid is showing is still holding its old request; ignore it
    assign instr_req_c   = instr_req & ~instr_valid;
    assign data_req_c    = (data_read | data_write) & ~data_valid;
    assign grant_data_c  = data_req_c & (~instr_req_c | (DATA_PRIORITY != 0));
    assign grant_instr_c = instr_req_c & ~grant_data_c;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wait_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || start_c) begin
            wait_cnt_q <= '0;
        end else if (state_q == BUS && bus.avm_waitrequest) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = (state_q == BUS) & bus.avm_waitrequest
                     & (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
    assign timeout_c      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_instr_c | (grant_data_c & ~misalign_c)) state_d = BUS;
            BUS:  if (~bus.avm_waitrequest | timeout_c) state_d = IDLE;
        endcase
    end

    always_comb begin
        start_c = 1'b0;
        fault_c = 1'b0;
        done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                start_c = grant_instr_c | (grant_data_c & ~misalign_c);
                fault_c = grant_data_c & misalign_c;
            end
            BUS: done_c = ~bus.avm_waitrequest | timeout_c;
        endcase
    end

    // Grant latch, bus strobes and completion registers
    always_ff @(posedge clk) begin
        if (reset) begin
            is_data_q       <= 1'b0;
            rd_q            <= 1'b0;
            wr_q            <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            be_q            <= '0;
            instr_rdata     <= '0;
            instr_valid     <= 1'b0;
            data_rdata      <= '0;
            data_byteenable <= '0;
            data_valid      <= 1'b0;
            data_error      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            data_valid  <= 1'b0;
            data_error  <= 1'b0;
            if (start_c) begin
                is_data_q <= grant_data_c;
                rd_q      <= ~grant_data_c | ~data_write;
                wr_q      <= grant_data_c & data_write;
                addr_q    <= grant_data_c ? data_address[31:2] : instr_address[31:2];
                be_q      <= grant_data_c ? be_c : 4'b1111;
                wdata_q   <= grant_data_c ? data_wdata : '0;
            end
            if (fault_c) begin
                data_valid      <= 1'b1;
                data_error      <= 1'b1;
                data_rdata      <= '0;
                data_byteenable <= be_c;
            end
            if (done_c) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
                if (is_data_q) begin
                    data_valid      <= 1'b1;
                    data_error      <= timeout_c;
                    data_rdata      <= timeout_c ? '0 : bus.avm_readdata;
                    data_byteenable <= be_q;
                end else begin
                    instr_valid <= 1'b1;
                    instr_rdata <= timeout_c ? '0 : bus.avm_readdata;
                end
            end
        end
    end

    assign bus.avm_address    = {addr_q, 2'b00};
    assign bus.avm_read       = rd_q;
    assign bus.avm_write      = wr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_byteenable = be_q;

    assign instr_stall = instr_req & ~instr_valid;
    assign data_stall  = (data_read | data_write) & ~data_valid;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: opcode vector table, scoreboard of completions,
// and hand sequences for contention, reset-in-BUS and (with MEM_ARB_TIMEOUT_EN) timeout.
module tb_mem_bus_arbiter;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        bit          rd;
        bit          wr;
        int          waits;
        logic [31:0] bus_rdata;
        logic [31:0] wdata;
        logic [3:0]  exp_be;
        bit          exp_err;
        int          exp_cycles;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        bit          is_data;
        bit          chk_rdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req = 1'b0;
    logic [31:0] instr_address = '0;
    logic [31:0] instr_rdata;
    logic        instr_valid;
    logic        instr_stall;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [5:0]  data_op = '0;
    logic [31:0] data_address = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic [3:0]  data_byteenable;
    logic        data_valid;
    logic        data_error;
    logic        data_stall;

    exp_t sb[$];
    vec_t vecs[17];
    int   n_checks = 0;
    int   n_pass = 0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_address(instr_address), .instr_rdata(instr_rdata),
        .instr_valid(instr_valid), .instr_stall(instr_stall),
        .data_read(data_read), .data_write(data_write), .data_op(data_op),
        .data_address(data_address), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_byteenable(data_byteenable), .data_valid(data_valid), .data_error(data_error),
        .data_stall(data_stall), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every valid pulse must match the oldest outstanding expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (instr_valid || data_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'({instr_valid, data_valid}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_requester", 32'(data_valid), 32'(e.is_data));
                if (e.is_data) begin
                    if (e.chk_rdata) check("data_rdata", data_rdata, e.rdata);
                    check("data_byteenable", 32'(data_byteenable), 32'(e.be));
                    check("data_error", 32'(data_error), 32'(e.err));
                end else begin
                    check("instr_rdata", instr_rdata, e.rdata);
                end
            end
        end
    end

    task automatic do_data(input vec_t v, input string tag);
        int          cyc;
        exp_t        e;
        logic [31:0] exp_addr;
        exp_addr    = {v.addr[31:2], 2'b00};
        e.is_data   = 1'b1;
        e.chk_rdata = !(v.wr && !v.exp_err);
        e.rdata     = v.exp_rdata;
        e.be        = v.exp_be;
        e.err       = v.exp_err;
        sb.push_back(e);
        data_op = v.op;
        data_address = v.addr;
        data_wdata = v.wdata;
        data_read = v.rd;
        data_write = v.wr;
        bus.avm_readdata = v.bus_rdata;
        bus.avm_waitrequest = 1'b1;
        tick();
        cyc = 0;
        while ((bus.avm_read || bus.avm_write) && cyc < 400) begin
            check({tag, "_addr"}, bus.avm_address, exp_addr);
            check({tag, "_be"}, 32'(bus.avm_byteenable), 32'(v.exp_be));
            check({tag, "_write"}, 32'({bus.avm_read, bus.avm_write}), v.wr ? 32'd1 : 32'd2);
            if (v.wr) check({tag, "_wdata"}, bus.avm_writedata, v.wdata);
            // Requester inputs change mid-transaction; bus must not follow them
            data_address = ~v.addr;
            data_op = ~v.op;
            data_wdata = ~v.wdata;
            bus.avm_waitrequest = (cyc < v.waits);
            tick();
            cyc++;
        end
        check({tag, "_strobe_cycles"}, 32'(cyc), 32'(v.exp_cycles));
        check({tag, "_valid"}, 32'(data_valid), 32'd1);
        check({tag, "_stall"}, 32'(data_stall), 32'd0);
        tick();
        check({tag, "_no_reissue"}, 32'({bus.avm_read, bus.avm_write}), 32'd0);
        data_read = 1'b0;
        data_write = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, input int waits, input logic [31:0] rdata);
        int   cyc;
        exp_t e;
        e = '{1'b0, 1'b1, rdata, 4'h0, 1'b0};
        sb.push_back(e);
        instr_address = addr;
        instr_req = 1'b1;
        bus.avm_readdata = rdata;
        bus.avm_waitrequest = 1'b1;
        tick();
        cyc = 0;
        while ((bus.avm_read || bus.avm_write) && cyc < 400) begin
            check("fetch_addr", bus.avm_address, {addr[31:2], 2'b00});
            check("fetch_be", 32'(bus.avm_byteenable), 32'hF);
            check("fetch_read", 32'({bus.avm_read, bus.avm_write}), 32'd2);
            check("fetch_stall", 32'(instr_stall), 32'd1);
            bus.avm_waitrequest = (cyc < waits);
            tick();
            cyc++;
        end
        check("fetch_strobe_cycles", 32'(cyc), 32'(waits + 1));
        check("fetch_valid", 32'(instr_valid), 32'd1);
        check("fetch_stall_done", 32'(instr_stall), 32'd0);
        tick();
        check("fetch_no_reissue", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        instr_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got still running, expected finished");
        $fatal(1);
    end

    initial begin
        exp_t e;
`ifdef MEM_ARB_TIMEOUT_EN
        vec_t tv;
`endif
        vecs[0]  = '{OP_LW,  32'h100, 1'b1, 1'b0, 0, 32'hDEADBEEF, 32'h0, 4'hF, 1'b0, 1, 32'hDEADBEEF};
        vecs[1]  = '{OP_LB,  32'h203, 1'b1, 1'b0, 3, 32'h11223344, 32'h0, 4'h8, 1'b0, 4, 32'h11223344};
        vecs[2]  = '{OP_LH,  32'h011, 1'b1, 1'b0, 0, 32'h55667788, 32'h0, 4'h3, 1'b1, 0, 32'h0};
        vecs[3]  = '{OP_LWL, 32'h022, 1'b1, 1'b0, 1, 32'hA1B2C3D4, 32'h0, 4'h7, 1'b0, 2, 32'hA1B2C3D4};
        vecs[4]  = '{OP_LWR, 32'h021, 1'b1, 1'b0, 0, 32'h0BADF00D, 32'h0, 4'hE, 1'b0, 1, 32'h0BADF00D};
        vecs[5]  = '{OP_LHU, 32'h012, 1'b1, 1'b0, 2, 32'hCAFEBABE, 32'h0, 4'hC, 1'b0, 3, 32'hCAFEBABE};
        vecs[6]  = '{OP_LBU, 32'h402, 1'b1, 1'b0, 0, 32'h01020304, 32'h0, 4'h4, 1'b0, 1, 32'h01020304};
        vecs[7]  = '{OP_SB,  32'h301, 1'b0, 1'b1, 1, 32'h0, 32'h0000AB00, 4'h2, 1'b0, 2, 32'h0};
        vecs[8]  = '{OP_SH,  32'h302, 1'b0, 1'b1, 0, 32'h0, 32'h12340000, 4'hC, 1'b0, 1, 32'h0};
        vecs[9]  = '{OP_SW,  32'h045, 1'b0, 1'b1, 0, 32'h0, 32'hFFFFFFFF, 4'hF, 1'b1, 0, 32'h0};
        vecs[10] = '{6'b111111, 32'h500, 1'b1, 1'b0, 0, 32'h76543210, 32'h0, 4'hF, 1'b0, 1, 32'h76543210};
        vecs[11] = '{6'b000000, 32'h502, 1'b1, 1'b0, 0, 32'h0, 32'h0, 4'hF, 1'b1, 0, 32'h0};
        vecs[12] = '{OP_LWL, 32'h023, 1'b1, 1'b0, 0, 32'h13572468, 32'h0, 4'hF, 1'b0, 1, 32'h13572468};
        vecs[13] = '{OP_LWR, 32'h020, 1'b1, 1'b0, 0, 32'h2468ACE0, 32'h0, 4'hF, 1'b0, 1, 32'h2468ACE0};
        vecs[14] = '{OP_SW,  32'h060, 1'b1, 1'b1, 2, 32'h0, 32'h5555AAAA, 4'hF, 1'b0, 3, 32'h0};
        vecs[15] = '{OP_LB,  32'h200, 1'b1, 1'b0, 0, 32'h99887766, 32'h0, 4'h1, 1'b0, 1, 32'h99887766};
        vecs[16] = '{OP_LH,  32'h017, 1'b1, 1'b0, 0, 32'h0, 32'h0, 4'hC, 1'b1, 0, 32'h0};

        bus.avm_readdata = '0;
        bus.avm_waitrequest = 1'b0;
        repeat (3) tick();
        check("rst_avm_address", bus.avm_address, 32'h0);
        check("rst_avm_strobes", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        check("rst_avm_writedata", bus.avm_writedata, 32'h0);
        check("rst_avm_be", 32'(bus.avm_byteenable), 32'h0);
        check("rst_instr_rdata", instr_rdata, 32'h0);
        check("rst_valids", 32'({instr_valid, data_valid, data_error}), 32'd0);
        check("rst_data_rdata", data_rdata, 32'h0);
        check("rst_data_be", 32'(data_byteenable), 32'h0);
        check("rst_stalls", 32'({instr_stall, data_stall}), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 17; i++) do_data(vecs[i], $sformatf("vec%0d", i));

        do_fetch(32'h0000_1004, 0, 32'h2402_0001);
        do_fetch(32'h0000_1008, 2, 32'h0000_000C);

        // Simultaneous fetch and store: data wins, fetch follows at the next IDLE edge
        e = '{1'b1, 1'b0, 32'h0, 4'hF, 1'b0};
        sb.push_back(e);
        e = '{1'b0, 1'b1, 32'h3C1C0001, 4'h0, 1'b0};
        sb.push_back(e);
        instr_address = 32'hBFC0_0000;
        instr_req = 1'b1;
        data_op = OP_SW;
        data_address = 32'h40;
        data_wdata = 32'h89ABCDEF;
        data_write = 1'b1;
        bus.avm_readdata = 32'h3C1C0001;
        bus.avm_waitrequest = 1'b0;
        tick();
        check("sim_write_first", 32'({bus.avm_read, bus.avm_write}), 32'd1);
        check("sim_write_addr", bus.avm_address, 32'h40);
        check("sim_write_be", 32'(bus.avm_byteenable), 32'hF);
        check("sim_write_data", bus.avm_writedata, 32'h89ABCDEF);
        check("sim_instr_stall_a", 32'(instr_stall), 32'd1);
        tick();
        check("sim_data_valid", 32'(data_valid), 32'd1);
        check("sim_instr_stall_b", 32'(instr_stall), 32'd1);
        tick();
        check("sim_fetch_read", 32'({bus.avm_read, bus.avm_write}), 32'd2);
        check("sim_fetch_addr", bus.avm_address, 32'hBFC0_0000);
        check("sim_fetch_be", 32'(bus.avm_byteenable), 32'hF);
        check("sim_instr_stall_c", 32'(instr_stall), 32'd1);
        data_write = 1'b0;
        tick();
        check("sim_instr_valid", 32'(instr_valid), 32'd1);
        check("sim_instr_stall_d", 32'(instr_stall), 32'd0);
        tick();
        check("sim_idle", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        instr_req = 1'b0;

        // Reset while the slave is stalling: transaction dropped, no valid pulse
        data_op = OP_LW;
        data_address = 32'h800;
        data_read = 1'b1;
        bus.avm_readdata = 32'h99999999;
        bus.avm_waitrequest = 1'b1;
        tick();
        check("rstbus_strobe", 32'(bus.avm_read), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rstbus_strobes", 32'({bus.avm_read, bus.avm_write}), 32'd0);
        check("rstbus_addr", bus.avm_address, 32'h0);
        check("rstbus_be", 32'(bus.avm_byteenable), 32'h0);
        check("rstbus_data_rdata", data_rdata, 32'h0);
        check("rstbus_data_be", 32'(data_byteenable), 32'h0);
        check("rstbus_instr_rdata", instr_rdata, 32'h0);
        check("rstbus_valids", 32'({instr_valid, data_valid, data_error}), 32'd0);
        reset = 1'b0;
        data_read = 1'b0;
        bus.avm_waitrequest = 1'b0;
        repeat (3) tick();
        check("rstbus_still_idle", 32'({bus.avm_read, bus.avm_write}), 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        tv = '{OP_LW, 32'h700, 1'b1, 1'b0, 1000, 32'h5A5A5A5A, 32'h0, 4'hF, 1'b1, 255, 32'h0};
        do_data(tv, "timeout");
`endif

        do_data(vecs[0], "post_reset_lw");
        repeat (2) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
